// File: rtl/quad_gen_if.sv
// Register-side control and quadrature output bundle for quad_gen.
interface quad_gen_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
);
  logic [WIDTH-1:0]     target_in;
  logic                 target_load;
  logic [WIDTH-1:0]     pos_in;
  logic                 pos_load;
  logic [DIV_WIDTH-1:0] period;
  logic                 stop;
  logic                 a;
  logic                 b;
  logic [WIDTH-1:0]     position;
  logic                 busy;
  logic                 done;

  modport master (
    output target_in, target_load, pos_in, pos_load, period, stop,
    input  a, b, position, busy, done
  );

  modport slave (
    input  target_in, target_load, pos_in, pos_load, period, stop,
    output a, b, position, busy, done
  );
endinterface

// File: rtl/quad_gen.sv
// Quadrature pattern generator: walks position toward target one A/B edge
// per step, at a programmable step period.
module quad_gen #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  quad_gen_if.slave   bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               state_next;
  logic [WIDTH-1:0]     target;
  logic [WIDTH-1:0]     pos;
  // phase holds {a,b} directly (Gray order), so one bit flips per step
  logic [1:0]           phase;
  logic [DIV_WIDTH-1:0] cnt;
  logic                 done_r;

  logic signed [WIDTH-1:0] diff;
  logic                 reverse;
  logic [DIV_WIDTH-1:0] thr;
  logic                 retarget_hit;
  logic                 step;
  logic [WIDTH-1:0]     pos_step;
  logic [1:0]           phase_step;
  logic [WIDTH-1:0]     tgt_eff;
  logic                 arrive;

  // Step decode: direction, period threshold, step and arrival conditions.
  always_comb begin
    diff         = target - pos;
    reverse      = (diff < 0);
    thr          = (bus.period == '0) ? '0 : bus.period - 1'b1;
    retarget_hit = bus.target_load && (bus.target_in == pos);
    step         = (state == RUN) && !bus.stop && !retarget_hit && (cnt >= thr);
    pos_step     = reverse ? pos - 1'b1 : pos + 1'b1;
    phase_step   = phase;
    case (phase)
      2'b00:   phase_step = reverse ? 2'b01 : 2'b10;
      2'b10:   phase_step = reverse ? 2'b00 : 2'b11;
      2'b11:   phase_step = reverse ? 2'b10 : 2'b01;
      default: phase_step = reverse ? 2'b11 : 2'b00;
    endcase
    // direction comes from the old target; arrival is judged against the
    // target that will be in force after this edge
    tgt_eff      = bus.target_load ? bus.target_in : target;
    arrive       = step && (pos_step == tgt_eff);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!bus.stop && !bus.pos_load && bus.target_load && (bus.target_in != pos))
          state_next = RUN;
      end
      RUN: begin
        if (bus.stop || retarget_hit || arrive)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: target, position, phase, rate counter and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target <= '0;
      pos    <= '0;
      phase  <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.stop) begin
        target <= pos;
        cnt    <= '0;
      end else if (state == IDLE) begin
        if (bus.pos_load) begin
          pos <= bus.pos_in;
        end else if (bus.target_load) begin
          target <= bus.target_in;
          cnt    <= '0;
        end
      end else begin
        if (bus.target_load)
          target <= bus.target_in;
        if (retarget_hit) begin
          cnt    <= '0;
          done_r <= 1'b1;
        end else if (step) begin
          cnt    <= '0;
          pos    <= pos_step;
          phase  <= phase_step;
          done_r <= arrive;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Outputs, all taken straight from registers.
  always_comb begin
    bus.a        = phase[1];
    bus.b        = phase[0];
    bus.position = pos;
    bus.busy     = (state == RUN);
    bus.done     = done_r;
  end

endmodule

// File: tb/tb_quad_gen.sv
// Directed self-checking bench for quad_gen.
module tb_quad_gen;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  quad_gen_if #(.WIDTH(8), .DIV_WIDTH(16)) bus ();

  quad_gen #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic load_target(input logic [7:0] t);
    bus.target_in   = t;
    bus.target_load = 1'b1;
    tick(1);
    bus.target_load = 1'b0;
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.target_in   = '0;
    bus.target_load = 1'b0;
    bus.pos_in      = '0;
    bus.pos_load    = 1'b0;
    bus.period      = 16'd4;
    bus.stop        = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // reset state
    check("rst_ab",   32'({bus.a, bus.b}), 32'b00);
    check("rst_pos",  32'(bus.position), 32'h00);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);

    // forward 3 steps at period 4
    load_target(8'h03);
    check("fw_busy0", 32'(bus.busy), 32'd1);
    check("fw_pos0",  32'(bus.position), 32'h00);
    tick(3);
    check("fw_ab_e3",  32'({bus.a, bus.b}), 32'b00);
    check("fw_pos_e3", 32'(bus.position), 32'h00);
    tick(1);
    check("fw_ab_e4",  32'({bus.a, bus.b}), 32'b10);
    check("fw_pos_e4", 32'(bus.position), 32'h01);
    tick(4);
    check("fw_ab_e8",  32'({bus.a, bus.b}), 32'b11);
    check("fw_pos_e8", 32'(bus.position), 32'h02);
    tick(4);
    check("fw_ab_e12",   32'({bus.a, bus.b}), 32'b01);
    check("fw_pos_e12",  32'(bus.position), 32'h03);
    check("fw_done_e12", 32'(bus.done), 32'd1);
    check("fw_busy_e12", 32'(bus.busy), 32'd0);
    tick(1);
    check("fw_done_e13", 32'(bus.done), 32'd0);

    // reverse 2 steps to 0xFE at period 1
    do_reset();
    bus.period = 16'd1;
    load_target(8'hFE);
    tick(1);
    check("rv_ab1",   32'({bus.a, bus.b}), 32'b01);
    check("rv_pos1",  32'(bus.position), 32'hFF);
    check("rv_busy1", 32'(bus.busy), 32'd1);
    tick(1);
    check("rv_ab2",   32'({bus.a, bus.b}), 32'b11);
    check("rv_pos2",  32'(bus.position), 32'hFE);
    check("rv_done2", 32'(bus.done), 32'd1);

    // period 0 behaves as 1; forward wrap 0xFF -> 0x00 -> 0x01
    do_reset();
    bus.period   = 16'd0;
    bus.pos_in   = 8'hFF;
    bus.pos_load = 1'b1;
    tick(1);
    bus.pos_load = 1'b0;
    check("wr_pos_pre", 32'(bus.position), 32'hFF);
    check("wr_ab_pre",  32'({bus.a, bus.b}), 32'b00);
    load_target(8'h01);
    tick(1);
    check("wr_pos1", 32'(bus.position), 32'h00);
    check("wr_ab1",  32'({bus.a, bus.b}), 32'b10);
    tick(1);
    check("wr_pos2",  32'(bus.position), 32'h01);
    check("wr_done2", 32'(bus.done), 32'd1);

    // half-range distance 0x80 goes reverse; stop mid-move
    do_reset();
    bus.period = 16'd1;
    load_target(8'h80);
    tick(1);
    check("hr_pos1", 32'(bus.position), 32'hFF);
    check("hr_ab1",  32'({bus.a, bus.b}), 32'b01);
    do_stop();
    check("hr_busy_stop", 32'(bus.busy), 32'd0);
    check("hr_done_stop", 32'(bus.done), 32'd0);
    check("hr_pos_stop",  32'(bus.position), 32'hFF);
    tick(3);
    check("hr_pos_hold", 32'(bus.position), 32'hFF);

    // stop after 3 steps of 0 -> 10 at period 2
    do_reset();
    bus.period = 16'd2;
    load_target(8'h0A);
    tick(6);
    check("st_pos3",  32'(bus.position), 32'h03);
    check("st_ab3",   32'({bus.a, bus.b}), 32'b01);
    check("st_busy3", 32'(bus.busy), 32'd1);
    do_stop();
    check("st_pos",  32'(bus.position), 32'h03);
    check("st_busy", 32'(bus.busy), 32'd0);
    check("st_done", 32'(bus.done), 32'd0);
    check("st_ab",   32'({bus.a, bus.b}), 32'b01);
    tick(4);
    check("st_pos_hold",  32'(bus.position), 32'h03);
    check("st_busy_hold", 32'(bus.busy), 32'd0);
    check("st_ab_hold",   32'({bus.a, bus.b}), 32'b01);

    // retarget to the current position mid-run
    do_reset();
    bus.period = 16'd2;
    load_target(8'h0A);
    tick(4);
    check("rt_pos2", 32'(bus.position), 32'h02);
    load_target(8'h02);
    check("rt_busy", 32'(bus.busy), 32'd0);
    check("rt_done", 32'(bus.done), 32'd1);
    check("rt_pos",  32'(bus.position), 32'h02);
    check("rt_ab",   32'({bus.a, bus.b}), 32'b11);
    tick(1);
    check("rt_done_off", 32'(bus.done), 32'd0);
    check("rt_pos_hold", 32'(bus.position), 32'h02);

    // pos_load beats target_load in IDLE
    bus.pos_in      = 8'h05;
    bus.pos_load    = 1'b1;
    bus.target_in   = 8'h09;
    bus.target_load = 1'b1;
    tick(1);
    bus.pos_load    = 1'b0;
    bus.target_load = 1'b0;
    check("pl_pos",  32'(bus.position), 32'h05);
    check("pl_busy", 32'(bus.busy), 32'd0);
    tick(2);
    check("pl_pos_hold",  32'(bus.position), 32'h05);
    check("pl_busy_hold", 32'(bus.busy), 32'd0);

    // pos_load during RUN is ignored
    bus.period = 16'd1;
    load_target(8'h07);
    check("pr_busy", 32'(bus.busy), 32'd1);
    bus.pos_in   = 8'h40;
    bus.pos_load = 1'b1;
    tick(1);
    bus.pos_load = 1'b0;
    check("pr_pos6", 32'(bus.position), 32'h06);
    tick(1);
    check("pr_pos7",  32'(bus.position), 32'h07);
    check("pr_done7", 32'(bus.done), 32'd1);

    // period shortened 8 -> 1 while cnt = 5
    do_reset();
    bus.period = 16'd8;
    load_target(8'h04);
    tick(5);
    check("pc_pos0", 32'(bus.position), 32'h00);
    bus.period = 16'd1;
    tick(1);
    check("pc_pos1", 32'(bus.position), 32'h01);
    tick(1);
    check("pc_pos2", 32'(bus.position), 32'h02);
    tick(1);
    check("pc_pos3",  32'(bus.position), 32'h03);
    check("pc_busy3", 32'(bus.busy), 32'd1);
    check("pc_ab3",   32'({bus.a, bus.b}), 32'b01);

    // asynchronous reset in the middle of a move
    #2;
    reset = 1'b1;
    #1;
    check("ar_ab",   32'({bus.a, bus.b}), 32'b00);
    check("ar_pos",  32'(bus.position), 32'h00);
    check("ar_busy", 32'(bus.busy), 32'd0);
    check("ar_done", 32'(bus.done), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    check("ar_pos_after", 32'(bus.position), 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
